// File: rtl/run_stats_dumper.sv
// run_stats_dumper: counts cycles until finish or watchdog, then streams a data-memory dump
// followed by one cycle-count beat over a valid/ready channel.
module run_stats_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int DUMP_DEPTH = 512,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  finish,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_kind,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  timed_out,
  output logic                  done
);
  typedef enum logic [2:0] {RUN, FETCH, CAPTURE, SEND, SENDCNT, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] idx;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic hit_to, last_word, accept;
  assign cnt_inc   = &cycle_count ? cycle_count : cycle_count + 1'b1;
  assign hit_to    = (TIMEOUT != 0) && (64'(cnt_inc) == 64'(TIMEOUT));
  assign last_word = idx == (ADDR_WIDTH+1)'(DUMP_DEPTH - 1);
  assign accept    = out_valid && out_ready;
  assign mem_rd    = state == FETCH;
  // idx only moves on the way into FETCH, so the address holds between reads
  assign mem_addr  = idx[ADDR_WIDTH-1:0];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = (finish || hit_to) ? FETCH : RUN;
      FETCH:   state_nx = CAPTURE;
      CAPTURE: state_nx = SEND;
      SEND:    state_nx = accept ? (last_word ? SENDCNT : FETCH) : SEND;
      SENDCNT: state_nx = accept ? DONE : SENDCNT;
      default: state_nx = DONE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_count <= '0;
      idx         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_kind    <= 1'b0;
      out_last    <= 1'b0;
      timed_out   <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (state == RUN) begin
        cycle_count <= cnt_inc;
        if (!finish && hit_to) timed_out <= 1'b1;
      end
      if (state == CAPTURE) begin
        out_data  <= mem_rdata;
        out_kind  <= 1'b0;
        out_last  <= 1'b0;
        out_valid <= 1'b1;
      end
      if (state == SEND && accept) begin
        if (last_word) begin
          out_data <= DATA_WIDTH'(cycle_count);
          out_kind <= 1'b1;
          out_last <= 1'b1;
        end else begin
          idx       <= idx + 1'b1;
          out_valid <= 1'b0;
        end
      end
      if (state == SENDCNT && accept) begin
        out_valid <= 1'b0;
        out_kind  <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_run_stats_dumper.sv
// tb_run_stats_dumper: three differently parameterised dumpers checked against a
// cycle-count/dump-order reference model with random memory contents.
module tb_run_stats_dumper;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;
  logic fin [3];
  logic rdy [3];
  logic rd [3], vld [3], kind [3], last [3], to [3], dn [3];
  logic [8:0] addr [3];
  logic [31:0] rdata [3], data [3];
  logic [31:0] cc0, cc1;
  logic [3:0] cc2;
  logic [31:0] mem [3][4];
  int errs = 0, checks = 0;

  run_stats_dumper #(.DUMP_DEPTH(4)) u0 (
    .CLK(CLK), .RST_N(RST_N), .finish(fin[0]), .mem_addr(addr[0]), .mem_rd(rd[0]),
    .mem_rdata(rdata[0]), .out_valid(vld[0]), .out_ready(rdy[0]), .out_data(data[0]),
    .out_kind(kind[0]), .out_last(last[0]), .cycle_count(cc0), .timed_out(to[0]), .done(dn[0]));
  run_stats_dumper #(.DUMP_DEPTH(4), .TIMEOUT(50)) u1 (
    .CLK(CLK), .RST_N(RST_N), .finish(fin[1]), .mem_addr(addr[1]), .mem_rd(rd[1]),
    .mem_rdata(rdata[1]), .out_valid(vld[1]), .out_ready(rdy[1]), .out_data(data[1]),
    .out_kind(kind[1]), .out_last(last[1]), .cycle_count(cc1), .timed_out(to[1]), .done(dn[1]));
  run_stats_dumper #(.DUMP_DEPTH(4), .CNT_WIDTH(4)) u2 (
    .CLK(CLK), .RST_N(RST_N), .finish(fin[2]), .mem_addr(addr[2]), .mem_rd(rd[2]),
    .mem_rdata(rdata[2]), .out_valid(vld[2]), .out_ready(rdy[2]), .out_data(data[2]),
    .out_kind(kind[2]), .out_last(last[2]), .cycle_count(cc2), .timed_out(to[2]), .done(dn[2]));

  always @(posedge CLK)
    for (int k = 0; k < 3; k++)
      if (rd[k]) rdata[k] <= mem[k][addr[k][1:0]];

  function automatic logic [31:0] get_cc(input int k);
    return (k == 0) ? cc0 : (k == 1) ? cc1 : {28'b0, cc2};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_scn(input int k, input int fe, input int stall_len, input int abort_beat);
    int t, n, e, nb, first, st;
    longint lim, ec;
    logic exp_to, aborted;
    int addrs[$];
    logic [33:0] beats[$];
    t = (k == 1) ? 50 : 0;
    lim = (64'd1 << ((k == 2) ? 4 : 32)) - 1;
    exp_to = (t != 0) && (fe == 0 || t < fe);
    n = exp_to ? t : fe;
    ec = (n > lim) ? lim : n;
    RST_N = 1'b0;
    for (int j = 0; j < 3; j++) begin
      fin[j] = 1'b0;
      rdy[j] = 1'b0;
    end
    for (int i = 0; i < 4; i++) mem[k][i] = $urandom;
    repeat (2) @(negedge CLK);
    chk("rst_cc", get_cc(k), 0);
    chk("rst_vld", vld[k], 0);
    chk("rst_done", dn[k], 0);
    RST_N = 1'b1;
    e = 0; nb = 0; first = -1; st = 0; aborted = 1'b0;
    while (!dn[k] && e < 300 && !aborted) begin
      fin[k] = (fe != 0 && e + 1 >= fe);
      if (vld[k] && first < 0) first = e;
      rdy[k] = !(nb == 1 && stall_len > 0 && st < stall_len);
      if (vld[k] && !rdy[k]) begin
        st++;
        chk("stall_data", data[k], mem[k][1]);
      end
      if (rd[k]) addrs.push_back(int'(addr[k]));
      if (abort_beat >= 0 && nb == abort_beat && vld[k]) begin
        rdy[k] = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("async_vld", vld[k], 0);
        chk("async_data", data[k], 0);
        chk("async_cc", get_cc(k), 0);
        chk("async_misc", {rd[k], addr[k], kind[k], last[k], to[k], dn[k]}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        chk("restart_cc0", get_cc(k), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("restart_cc1", get_cc(k), 1);
        chk("restart_no_beat", vld[k], 0);
        aborted = 1'b1;
      end else begin
        if (vld[k] && rdy[k]) begin
          beats.push_back({kind[k], last[k], data[k]});
          nb++;
        end
        @(posedge CLK);
        e++;
        @(negedge CLK);
      end
    end
    if (!aborted) begin
      chk("done", dn[k], 1);
      chk("n_beats", beats.size(), 5);
      for (int i = 0; i < 5 && i < beats.size(); i++)
        chk("beat", beats[i], (i < 4) ? {2'b00, mem[k][i]} : {2'b11, 32'(ec)});
      chk("n_rd", addrs.size(), 4);
      for (int i = 0; i < 4 && i < addrs.size(); i++) chk("rd_addr", addrs[i], i);
      chk("cc", get_cc(k), ec);
      chk("timed_out", to[k], exp_to);
      chk("first_vld", first, n + 2);
      chk("idle_after", {vld[k], kind[k], last[k]}, 0);
      if (stall_len > 0) chk("stall_len", st, stall_len);
    end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      fin[j] = 1'b0;
      rdy[j] = 1'b0;
    end
    run_scn(0, 100, 0, -1);
    run_scn(0, 100, 5, -1);
    run_scn(1, 0, 0, -1);
    run_scn(1, 50, 0, -1);
    run_scn(2, 20, 0, -1);
    rdy[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fin[2] = i[0];
      @(negedge CLK);
      chk("done_no_beat", vld[2], 0);
    end
    chk("sat_frozen", cc2, 15);
    chk("sat_done", dn[2], 1);
    run_scn(0, 30, 0, 2);
    run_scn(0, 10, 0, -1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
